kvs_lookup_arbiter: RTL

- Shares the single KVS lookup port of db_top between two packet-side requesters, e.g. two Ethernet port parsers.
- Round-robin arbitrates key/flag lookup requests onto the KVS input and tags each issued request.
- Routes each in-order KVS result (out_valid/out_flag) back to the requester that issued it.
- Sits in the db_clk domain, between the eth_top lookup outputs and db_top.

---
 rtl/kvs_lookup_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/kvs_lookup_arbiter.sv
// kvs_lookup_arbiter: shares one KVS lookup port between two requesters.
// Requests are granted round-robin, and each issued request is tagged with
// its requester id in a small FIFO. The KVS returns results in issue order,
// so the FIFO head always names the requester that owns the next result.
module kvs_lookup_arbiter #(
   parameter int KEY_SIZE  = 96,
   parameter int TAG_DEPTH = 16,
   parameter int TAG_AW    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_SIZE-1:0] req0_key,
   input  logic [3:0]          req0_flag,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [KEY_SIZE-1:0] req1_key,
   input  logic [3:0]          req1_flag,
   input  logic                req1_valid,
   output logic                req1_ready,
   output logic [KEY_SIZE-1:0] db_key,
   output logic [3:0]          db_flag,
   output logic                db_valid,
   input  logic                db_ready,
   input  logic                db_out_valid,
   input  logic [3:0]          db_out_flag,
   output logic                resp0_valid,
   output logic [3:0]          resp0_flag,
   output logic                resp1_valid,
   output logic [3:0]          resp1_flag,
   output logic [TAG_AW:0]     inflight,
   output logic                err_orphan
);

   localparam logic [TAG_AW:0]   FULL_CNT = (TAG_AW+1)'(TAG_DEPTH);
   localparam logic [TAG_AW:0]   CNT_ONE  = (TAG_AW+1)'(1);
   localparam logic [TAG_AW-1:0] PTR_ONE  = (TAG_AW)'(1);

   logic              last_grant;
   logic [TAG_AW-1:0] wr_ptr;
   logic [TAG_AW-1:0] rd_ptr;
   logic              tag_mem [TAG_DEPTH];
   logic              slot_free;
   logic              can_grant;
   logic              grant0;
   logic              grant1;
   logic              push;
   logic              pop;
   logic              orphan;
   logic              head_tag;
   logic [TAG_AW:0]   inflight_nxt;

   // Round-robin grant; grant uses the registered inflight count only.
   always_comb begin
      slot_free = !db_valid || db_ready;
      can_grant = slot_free && (inflight < FULL_CNT);
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (can_grant) begin
         if (req0_valid && req1_valid) begin
            if (last_grant) begin
               grant0 = 1'b1;
            end else begin
               grant1 = 1'b1;
            end
         end else if (req0_valid) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end else begin
            grant0 = 1'b0;
            grant1 = 1'b0;
         end
      end else begin
         grant0 = 1'b0;
         grant1 = 1'b0;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign push       = grant0 || grant1;
   assign pop        = db_out_valid && (inflight != '0);
   assign orphan     = db_out_valid && (inflight == '0);
   assign head_tag   = tag_mem[rd_ptr];

   // Next outstanding count: push and pop together leave it unchanged.
   always_comb begin
      inflight_nxt = inflight;
      case ({push, pop})
         2'b10:   inflight_nxt = inflight + CNT_ONE;
         2'b01:   inflight_nxt = inflight - CNT_ONE;
         default: inflight_nxt = inflight;
      endcase
   end

   // Issue register toward the KVS, holding while the KVS stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_key     <= '0;
         db_flag    <= 4'h0;
         db_valid   <= 1'b0;
         last_grant <= 1'b1;
      end else if (push) begin
         db_key     <= grant1 ? req1_key : req0_key;
         db_flag    <= grant1 ? req1_flag : req0_flag;
         db_valid   <= 1'b1;
         last_grant <= grant1;
      end else if (db_ready) begin
         db_valid   <= 1'b0;
      end
   end

   // Tag storage; emptiness is tracked by the pointers and inflight.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr] <= grant1;
      end
   end

   // Tag FIFO pointers and outstanding-lookup counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         inflight <= inflight_nxt;
      end
   end

   // Route each result to the owner of the head tag one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp0_valid <= 1'b0;
         resp0_flag  <= 4'h0;
         resp1_valid <= 1'b0;
         resp1_flag  <= 4'h0;
         err_orphan  <= 1'b0;
      end else begin
         resp0_valid <= pop && !head_tag;
         resp1_valid <= pop && head_tag;
         if (pop && !head_tag) begin
            resp0_flag <= db_out_flag;
         end
         if (pop && head_tag) begin
            resp1_flag <= db_out_flag;
         end
         err_orphan <= err_orphan || orphan;
      end
   end

endmodule
